detector_conjunto_programable: RTL
==================================

# detector_conjunto_programable

Programmable, pipelined set-membership detector. It flags each valid `ANCHO`-bit input word that belongs to a run-time-loadable set of values and counts the hits. It generalises the team's fixed 6-bit "is this one of N numbers" comparators: any width, a writable membership table instead of hard-wired gates, an optional complement mode, and a streaming valid interface. It sits between the input word source and the downstream decision logic that consumes `Salida`/`Valido_out`.

## Interface
Parameters:
- `ANCHO`, 6: input word width; the membership table holds 2^`ANCHO` bits.
- `ANCHO_CUENTA`, 16: width of the hit counter.
- `TABLA_INICIAL`, all zeros (2^`ANCHO` bits): table contents after reset. Bit k = 1 means value k is in the set.

Ports:
- `Reloj` in 1: single clock; all state updates on its rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `Valido_in` in 1: `Entrada` carries a word to test this cycle.
- `Entrada` in `ANCHO`: word under test.
- `Invertir` in 1: when 1, report non-membership (complement set). Sampled together with `Entrada`.
- `Escribir` in 1: table write strobe.
- `DirEscritura` in `ANCHO`: table bit address.
- `DatoEscritura` in 1: new membership bit.
- `LimpiarCuenta` in 1: synchronous clear of `Cuenta`.
- `Valido_out` out 1: `Salida` is valid this cycle.
- `Salida` out 1: membership result for the word accepted two edges earlier.
- `Cuenta` out `ANCHO_CUENTA`: saturating count of results with `Salida`=1.

## Operation
- Reset (`Reset_n`=0 at an edge): table <= `TABLA_INICIAL`; both pipeline stages invalidated; `Valido_out`=0, `Salida`=0, `Cuenta`=0. Reset overrides writes, clears, and in-flight words; words in flight are dropped, not reported.
- Stage 1 (edge E1): registers `Valido_in`, `Entrada`, `Invertir`. No back-pressure; a new word may be accepted every cycle.
- Stage 2 (edge E2 = E1+1): `Salida` <= table[`Entrada_reg`] XOR `Invertir_reg`. `Valido_out` <= stage-1 valid. When stage 1 is invalid, `Salida` <= 0.
- Table write: at any edge with `Escribir`=1, table[`DirEscritura`] <= `DatoEscritura`. Only one bit changes per write.
- Read/write collision: the stage-2 lookup at edge E uses table contents from before E's write (read-before-write). The new bit affects lookups from edge E+1 onward.
- Counter: at an edge where stage 2 produces `Valido_out`=1 and `Salida`=1, `Cuenta` += 1. It saturates at 2^`ANCHO_CUENTA`-1 and does not wrap.
- `LimpiarCuenta`=1 sets `Cuenta` <= 0 and takes priority over a simultaneous increment; that hit is lost.
- No internal FSM beyond the 2-stage valid pipeline. Throughput is 1 word per cycle.

## Timing
- Latency: a word presented with `Valido_in`=1 before edge N gives `Valido_out`/`Salida` registered at edge N+1, visible after N+1.
- `Cuenta` reflects a hit at the same edge as that hit's `Salida`.
- All outputs are registered; there are no combinational input-to-output paths.
- Back-to-back valid words produce back-to-back results in order.
- Deasserting `Reset_n` gives `Valido_out`=0 for at least two cycles after the first post-reset `Valido_in`.

## Test plan
- Reset and load: keep `Reset_n`=0 for 2 edges with default table. Check `Valido_out`=0, `Salida`=0, `Cuenta`=0. Write bits 1, 2, 3, 5, 10, 12, 13, 15 to 1. Stream `Entrada`=0..63 with `Invertir`=0. Expect `Salida`=1 exactly for those 8 values, each 2 edges after input. Expect `Cuenta`=8.
- Complement mode: same table, stream 0..63 with `Invertir`=1. Expect 56 hits; `Cuenta` goes 8 -> 64. Toggle `Invertir` per word and check results track the per-word value.
- Collision: table[7]=0. In one cycle set `Escribir`=1, `DirEscritura`=7, `DatoEscritura`=1 while stage 1 holds `Entrada`=7. Expect `Salida`=0. The next query of 7 gives `Salida`=1.
- Counter edges: with `ANCHO_CUENTA`=4 and all-ones table, stream 20 valid words. Expect `Cuenta` to stop at 15. Assert `LimpiarCuenta` on a hit cycle; expect `Cuenta`=0, not 1.
- Reset mid-stream: stream valid words continuously and pull `Reset_n` low for one edge. Expect no `Valido_out` for the in-flight words, the table restored to `TABLA_INICIAL`, and `Cuenta`=0.
- Gaps: alternate `Valido_in` 1/0 over 10 cycles. `Valido_out` follows the same pattern delayed by 2, with `Salida`=0 on invalid cycles.

Source files
------------

// File: rtl/detector_conjunto_programable.sv
// Pipelined set-membership detector: a run-time writable 2^ANCHO-bit table flags each
// valid input word (optionally complemented) two edges later and counts hits with saturation.
module detector_conjunto_programable #(
  parameter int unsigned               ANCHO         = 6,
  parameter int unsigned               ANCHO_CUENTA  = 16,
  parameter logic [(1 << ANCHO)-1:0]   TABLA_INICIAL = '0
) (
  input  logic                    Reloj,
  input  logic                    Reset_n,
  input  logic                    Valido_in,
  input  logic [ANCHO-1:0]        Entrada,
  input  logic                    Invertir,
  input  logic                    Escribir,
  input  logic [ANCHO-1:0]        DirEscritura,
  input  logic                    DatoEscritura,
  input  logic                    LimpiarCuenta,
  output logic                    Valido_out,
  output logic                    Salida,
  output logic [ANCHO_CUENTA-1:0] Cuenta
);

  localparam int unsigned Entradas = 1 << ANCHO;

  logic [Entradas-1:0]     tabla_q, tabla_d;
  logic                    valido1_q;
  logic [ANCHO-1:0]        entrada1_q;
  logic                    invertir1_q;
  logic                    valido2_q;
  logic                    salida_q, salida_d;
  logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;

  always_comb begin
    tabla_d = tabla_q;
    if (Escribir) begin
      tabla_d[DirEscritura] = DatoEscritura;
    end
  end

  // Lookup reads tabla_q, so a write at the same edge is only seen from the next edge on.
  assign salida_d = valido1_q & (tabla_q[entrada1_q] ^ invertir1_q);

  always_comb begin
    cuenta_d = cuenta_q;
    if (LimpiarCuenta) begin
      cuenta_d = '0;
    end else if (salida_d && (cuenta_q != {ANCHO_CUENTA{1'b1}})) begin
      cuenta_d = cuenta_q + ANCHO_CUENTA'(1);
    end
  end

  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      tabla_q     <= TABLA_INICIAL;
      valido1_q   <= 1'b0;
      entrada1_q  <= '0;
      invertir1_q <= 1'b0;
      valido2_q   <= 1'b0;
      salida_q    <= 1'b0;
      cuenta_q    <= '0;
    end else begin
      tabla_q     <= tabla_d;
      valido1_q   <= Valido_in;
      entrada1_q  <= Entrada;
      invertir1_q <= Invertir;
      valido2_q   <= valido1_q;
      salida_q    <= salida_d;
      cuenta_q    <= cuenta_d;
    end
  end

  assign Valido_out = valido2_q;
  assign Salida     = salida_q;
  assign Cuenta     = cuenta_q;

endmodule
